// File: rtl/multicycle_cu_if.sv
// Shared instruction/data memory port between the multi-cycle control unit
// and the memory system: request, write strobe, address select, ready.
interface multicycle_cu_if;
  logic mem_req;
  logic write_mem;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output write_mem,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  write_mem,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit for the 3-bit-opcode RISC core.
// FETCH/DECODE/EXEC/MEM/WB over one shared memory port, with halt and fault.
module multicycle_cu #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32,
  parameter int TO_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_cu_if.master  bus,
  input  logic [2:0]       opcode,
  input  logic             halt_flag,
  input  logic             EQ_out,
  output logic             ir_load,
  output logic             write_en_reg,
  output logic [1:0]       wb_sel,
  output logic             ADD,
  output logic             NAND,
  output logic             PASS1,
  output logic             EQ,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             BR,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  state_t           state;
  logic [TO_W-1:0]  wcnt;
  logic [TO_W:0]    wnext;
  logic [CNT_W-1:0] ret_q;
  logic             is_mem;
  logic             accept;
  logic             waiting;
  logic             timed_out;
  logic             retire;

  // {ADD, NAND, PASS1, EQ}
  function automatic logic [3:0] alu_dec(input logic [2:0] op);
    logic [3:0] sel;
    unique case (op)
      3'b000, 3'b001,
      3'b100, 3'b101: sel = 4'b1000;
      3'b010:         sel = 4'b0100;
      3'b011, 3'b111: sel = 4'b0010;
      default:        sel = 4'b0001;
    endcase
    return sel;
  endfunction

  assign is_mem  = (state == S_FETCH) || (state == S_MEM);
  assign accept  = is_mem && bus.mem_ready;
  assign waiting = is_mem && !bus.mem_ready;
  assign wnext   = {1'b0, wcnt} + (TO_W+1)'(1);

  // accept has priority: a late ready on the limit cycle is not a fault
  assign timed_out = (TIMEOUT > 0) && waiting
                  && (wnext == (TO_W+1)'(TIMEOUT));

  assign retire = (state == S_WB)
               || (state == S_EXEC && opcode == OP_BEQ)
               || (state == S_MEM && accept && opcode == OP_SW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      wcnt  <= '0;
      ret_q <= '0;
    end else begin
      if (retire)
        ret_q <= ret_q + CNT_W'(1);
      wcnt <= waiting ? wnext[TO_W-1:0] : '0;
      unique case (state)
        S_FETCH: begin
          if (accept)
            state <= S_DECODE;
          else if (timed_out)
            state <= S_FAULT;
        end
        S_DECODE: begin
          if (opcode == OP_JALR && halt_flag)
            state <= S_HALT;
          else
            state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (opcode)
            OP_BEQ:       state <= S_FETCH;
            OP_LW, OP_SW: state <= S_MEM;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (accept)
            state <= (opcode == OP_SW) ? S_FETCH : S_WB;
          else if (timed_out)
            state <= S_FAULT;
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.write_mem = 1'b0;
    bus.addr_sel  = 1'b0;
    ir_load       = 1'b0;
    write_en_reg  = 1'b0;
    wb_sel        = 2'd0;
    {ADD, NAND, PASS1, EQ} = 4'b0000;
    pc_load       = 1'b0;
    pc_src        = 2'd0;
    BR            = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    retired       = '0;
    if (!rst) begin
      retired = ret_q;
      unique case (state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          ir_load     = bus.mem_ready;
          pc_load     = bus.mem_ready;
        end
        S_EXEC: begin
          {ADD, NAND, PASS1, EQ} = alu_dec(opcode);
          if (opcode == OP_BEQ) begin
            BR      = EQ_out;
            pc_load = EQ_out;
            pc_src  = 2'd1;
          end
        end
        S_MEM: begin
          bus.mem_req   = 1'b1;
          bus.addr_sel  = 1'b1;
          bus.write_mem = (opcode == OP_SW);
          ADD           = 1'b1;
        end
        S_WB: begin
          write_en_reg = 1'b1;
          {ADD, NAND, PASS1, EQ} = alu_dec(opcode);
          unique case (opcode)
            OP_LW:   wb_sel = 2'd1;
            OP_JALR: begin
              wb_sel  = 2'd2;
              pc_load = 1'b1;
              pc_src  = 2'd2;
            end
            default: wb_sel = 2'd0;
          endcase
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed per-cycle vector bench for multicycle_cu, plus a bounded
// timeout-latency sequence.
module tb_multicycle_cu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic        halt_flag;
  logic        EQ_out;
  logic        rdy;
  logic        ir_load, write_en_reg;
  logic [1:0]  wb_sel;
  logic        ADD, NAND, PASS1, EQ;
  logic        pc_load;
  logic [1:0]  pc_src;
  logic        BR, halted, fault;
  logic [31:0] retired;
  logic [16:0] act;

  int total = 0;
  int bad   = 0;

  multicycle_cu_if bus();
  assign bus.mem_ready = rdy;

  always #5 clk = ~clk;

  multicycle_cu #(.TIMEOUT(15), .CNT_W(32), .TO_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .opcode       (opcode),
    .halt_flag    (halt_flag),
    .EQ_out       (EQ_out),
    .ir_load      (ir_load),
    .write_en_reg (write_en_reg),
    .wb_sel       (wb_sel),
    .ADD          (ADD),
    .NAND         (NAND),
    .PASS1        (PASS1),
    .EQ           (EQ),
    .pc_load      (pc_load),
    .pc_src       (pc_src),
    .BR           (BR),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  assign act = {bus.mem_req, bus.write_mem, bus.addr_sel, ir_load,
                write_en_reg, wb_sel, ADD, NAND, PASS1, EQ,
                pc_load, pc_src, BR, halted, fault};

  typedef struct {
    string       name;
    bit          r;
    bit [2:0]    op;
    bit          hf;
    bit          eq;
    bit          rdy;
    logic [16:0] exp;
    int unsigned ret;
  } vec_t;

  vec_t tv[$];

  function automatic logic [16:0] mk(
    bit mreq, bit wm, bit as, bit irl, bit we, bit [1:0] wbs,
    bit [3:0] alu, bit pcl, bit [1:0] pcs, bit br, bit h, bit f);
    return {mreq, wm, as, irl, we, wbs, alu, pcl, pcs, br, h, f};
  endfunction

  task automatic p(string n, bit r, bit [2:0] op, bit hf, bit eq,
                   bit rd, logic [16:0] e, int unsigned rt);
    vec_t v;
    v.name = n; v.r = r; v.op = op; v.hf = hf;
    v.eq = eq; v.rdy = rd; v.exp = e; v.ret = rt;
    tv.push_back(v);
  endtask

  initial begin
    logic [16:0] Z, FACC, FWT, EXADD, WBADD, MLW, MSW, WBLW;
    logic [16:0] BEQT, BEQN, EXNAND, WBNAND, EXP1, WBJR, HLT, FLT;
    int  n;
    bit  done;

    rst = 1'b1; opcode = 3'd0; halt_flag = 1'b0;
    EQ_out = 1'b0; rdy = 1'b1;

    Z      = '0;
    FACC   = mk(1,0,0,1,0,2'd0,4'b0000,1,2'd0,0,0,0);
    FWT    = mk(1,0,0,0,0,2'd0,4'b0000,0,2'd0,0,0,0);
    EXADD  = mk(0,0,0,0,0,2'd0,4'b1000,0,2'd0,0,0,0);
    WBADD  = mk(0,0,0,0,1,2'd0,4'b1000,0,2'd0,0,0,0);
    MLW    = mk(1,0,1,0,0,2'd0,4'b1000,0,2'd0,0,0,0);
    MSW    = mk(1,1,1,0,0,2'd0,4'b1000,0,2'd0,0,0,0);
    WBLW   = mk(0,0,0,0,1,2'd1,4'b1000,0,2'd0,0,0,0);
    BEQT   = mk(0,0,0,0,0,2'd0,4'b0001,1,2'd1,1,0,0);
    BEQN   = mk(0,0,0,0,0,2'd0,4'b0001,0,2'd1,0,0,0);
    EXNAND = mk(0,0,0,0,0,2'd0,4'b0100,0,2'd0,0,0,0);
    WBNAND = mk(0,0,0,0,1,2'd0,4'b0100,0,2'd0,0,0,0);
    EXP1   = mk(0,0,0,0,0,2'd0,4'b0010,0,2'd0,0,0,0);
    WBJR   = mk(0,0,0,0,1,2'd2,4'b0010,1,2'd2,0,0,0);
    HLT    = mk(0,0,0,0,0,2'd0,4'b0000,0,2'd0,0,1,0);
    FLT    = mk(0,0,0,0,0,2'd0,4'b0000,0,2'd0,0,0,1);

    // reset, then add with zero waits
    p("rst",   1,3'd0,0,0,1,Z,0);
    p("rst",   1,3'd0,0,0,1,Z,0);
    p("add_f", 0,3'd0,0,0,1,FACC,0);
    p("add_d", 0,3'd0,0,0,1,Z,0);
    p("add_x", 0,3'd0,0,0,1,EXADD,0);
    p("add_w", 0,3'd0,0,0,1,WBADD,0);
    // lw with three wait cycles in MEM
    p("lw_f",  0,3'd4,0,0,1,FACC,1);
    p("lw_d",  0,3'd4,0,0,1,Z,1);
    p("lw_x",  0,3'd4,0,0,1,EXADD,1);
    for (int i = 0; i < 3; i++) p("lw_mw", 0,3'd4,0,0,0,MLW,1);
    p("lw_ma", 0,3'd4,0,0,1,MLW,1);
    p("lw_w",  0,3'd4,0,0,1,WBLW,1);
    // beq taken then not taken
    p("beq1_f",0,3'd6,0,1,1,FACC,2);
    p("beq1_d",0,3'd6,0,1,1,Z,2);
    p("beq1_x",0,3'd6,0,1,1,BEQT,2);
    p("beq0_f",0,3'd6,0,0,1,FACC,3);
    p("beq0_d",0,3'd6,0,0,1,Z,3);
    p("beq0_x",0,3'd6,0,0,1,BEQN,3);
    // sw zero-wait, nand
    p("sw_f",  0,3'd5,0,0,1,FACC,4);
    p("sw_d",  0,3'd5,0,0,1,Z,4);
    p("sw_x",  0,3'd5,0,0,1,EXADD,4);
    p("sw_m",  0,3'd5,0,0,1,MSW,4);
    p("nd_f",  0,3'd2,0,0,1,FACC,5);
    p("nd_d",  0,3'd2,0,0,1,Z,5);
    p("nd_x",  0,3'd2,0,0,1,EXNAND,5);
    p("nd_w",  0,3'd2,0,0,1,WBNAND,5);
    // jalr, then HALT
    p("jr_f",  0,3'd7,0,0,1,FACC,6);
    p("jr_d",  0,3'd7,0,0,1,Z,6);
    p("jr_x",  0,3'd7,0,0,1,EXP1,6);
    p("jr_w",  0,3'd7,0,0,1,WBJR,6);
    p("hlt_f", 0,3'd7,1,0,1,FACC,7);
    p("hlt_d", 0,3'd7,1,0,1,Z,7);
    for (int i = 0; i < 20; i++) p("halt", 0,3'd7,1,0,1,HLT,7);
    // fetch timeout, then accept on the last allowed cycle
    p("rst2",  1,3'd0,0,0,0,Z,0);
    for (int i = 0; i < 15; i++) p("to_wait", 0,3'd0,0,0,0,FWT,0);
    for (int i = 0; i < 3; i++)  p("fault",   0,3'd0,0,0,1,FLT,0);
    p("rst3",  1,3'd0,0,0,0,Z,0);
    for (int i = 0; i < 14; i++) p("late_wait", 0,3'd0,0,0,0,FWT,0);
    p("late_acc",0,3'd0,0,0,1,FACC,0);
    p("late_d",  0,3'd0,0,0,1,Z,0);
    p("late_x",  0,3'd0,0,0,1,EXADD,0);
    p("late_w",  0,3'd0,0,0,1,WBADD,0);
    // sw with reset on its second MEM wait cycle
    p("swr_f", 0,3'd5,0,0,1,FACC,1);
    p("swr_d", 0,3'd5,0,0,1,Z,1);
    p("swr_x", 0,3'd5,0,0,1,EXADD,1);
    p("swr_mw",0,3'd5,0,0,0,MSW,1);
    p("swr_rs",1,3'd5,0,0,0,Z,0);
    p("swr_f2",0,3'd5,0,0,0,FWT,0);

    foreach (tv[i]) begin
      @(negedge clk);
      rst       = tv[i].r;
      opcode    = tv[i].op;
      halt_flag = tv[i].hf;
      EQ_out    = tv[i].eq;
      rdy       = tv[i].rdy;
      #1;
      total++;
      if (act !== tv[i].exp || retired !== tv[i].ret) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%h ret=%0d want out=%h ret=%0d",
                 tv[i].name, i, act, retired, tv[i].exp, tv[i].ret);
      end
    end

    // bounded count of request cycles before the fault appears
    @(negedge clk);
    rst = 1'b1; rdy = 1'b0; opcode = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    n = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (fault) done = 1'b1;
      else begin
        if (bus.mem_req) n++;
        @(negedge clk);
      end
    end
    total++;
    if (!done || n != 15) begin
      bad++;
      $display("FAIL to_latency: got done=%0d waits=%0d want done=1 waits=15",
               done, n);
    end
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL to_req_drop: got mem_req=%b want 0", bus.mem_req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Parametrised multi-cycle successor to the single-cycle combinational control unit of the 3-bit-opcode RISC core: add, addi, nand, lui, lw, sw, beq, jalr.
- A Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB so one shared memory port serves instruction and data traffic through a req/ready handshake.
- Adds three behaviours the single-cycle unit lacks:
  - wait states;
  - a memory-timeout fault;
  - halt, plus a retired-instruction counter.
- Sits between the instruction register / EQ comparator and the datapath muxes, register file and memory port.

Parameters:
TIMEOUT, 15, max cycles a memory request may wait for mem_ready before fault; 0 disables timeout
CNT_W, 32, width of retired-instruction counter
TO_W, 4, width of wait counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
opcode  in  3  instruction opcode from IR; stable from DECODE until next FETCH
halt_flag  in  1  IR immediate nonzero; qualifies jalr (111) as HALT
EQ_out  in  1  register-equality result, sampled in EXEC
mem_ready  in  1  memory completes current request on a cycle where mem_req&&mem_ready
mem_req  out  1  memory request, held until accepted
write_mem  out  1  memory write strobe (valid with mem_req)
addr_sel  out  1  0=PC, 1=ALU result drives memory address
ir_load  out  1  load IR from memory read data
write_en_reg  out  1  register-file write enable
wb_sel  out  2  0=ALU, 1=mem data, 2=PC+1
ADD, NAND, PASS1, EQ  out  1 each  one-hot ALU function select
pc_load  out  1  load PC
pc_src  out  2  0=PC+1, 1=branch target, 2=register (jalr)
BR  out  1  branch taken (EXEC of beq with EQ_out=1)
halted  out  1  sticky, core stopped by HALT
fault  out  1  sticky, memory timeout occurred
retired  out  CNT_W  count of completed instructions

Behaviour:
- Synchronous reset: state=FETCH, wait counter=0, retired=0, halted=0, fault=0.
- While rst is high, all outputs are forced to 0, including mem_req.
- First post-reset cycle is FETCH with mem_req=1.
- Every strobe not listed for a state is 0.
- States and outputs:
  - FETCH: mem_req=1, addr_sel=0. On accept (mem_req&&mem_ready): ir_load=1, pc_load=1, pc_src=0 in that same cycle, then -> DECODE. Otherwise stay.
  - DECODE: no strobes. -> S_HALT if opcode=111&&halt_flag, else -> EXEC.
  - EXEC: ALU select by opcode:
    - 000, 001, 100, 101: ADD=1.
    - 010: NAND=1.
    - 011, 111: PASS1=1.
    - 110: EQ=1, BR=EQ_out, pc_load=EQ_out, pc_src=1; retire; -> FETCH.
    - 100, 101: -> MEM.
    - All other opcodes: -> WB.
  - MEM: mem_req=1, addr_sel=1, ADD=1, write_mem=(opcode==101). On accept: sw retires -> FETCH; lw -> WB.
  - WB: write_en_reg=1.
    - wb_sel: 1 for lw, 2 for jalr, else 0; the ALU select from EXEC is re-asserted.
    - jalr additionally sets pc_load=1, pc_src=2.
    - Retire; -> FETCH.
  - S_HALT: halted=1, all strobes 0, absorbing until reset. The HALT instruction itself is not counted.
  - S_FAULT: fault=1, all strobes 0, absorbing until reset.
- Zero-wait latency, in cycles per instruction:
  - beq: 3.
  - add/addi/nand/lui/jalr/sw: 4.
  - lw: 5.
- Each waited cycle adds exactly 1 cycle.
- Retire: retired increments by 1 on the final cycle of each instruction and wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on every accept.
  - Increments each cycle mem_req=1 && mem_ready=0.
  - If TIMEOUT>0 and it reaches TIMEOUT while still waiting, next state is S_FAULT (mem_req drops).
  - mem_ready arriving in the same cycle the count hits TIMEOUT counts as accept; accept wins.
- mem_ready while mem_req=0 is ignored.
- Unknown or X opcode cannot occur: the 3-bit space is fully decoded.
- Reset asserted mid-instruction, including mid-wait: no retire, no register/memory strobe in that cycle; restart at FETCH.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1, opcode=000 -> all outputs 0 during reset; then FETCH(mem_req=1, ir_load=1), DECODE, EXEC(ADD=1), WB(write_en_reg=1, wb_sel=0); retired=1 after cycle 4.
- lw (100) with mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles with write_mem=0 and addr_sel=1, then WB wb_sel=1; total 8 cycles; retired +1.
- beq (110) with EQ_out=1, then beq with EQ_out=0 -> first: EXEC BR=1, pc_load=1, pc_src=1; second: BR=0, pc_load=0; each 3 cycles; retired +2.
- jalr (111, halt_flag=0) then jalr with halt_flag=1 -> WB write_en_reg=1, wb_sel=2, pc_load=1, pc_src=2; second reaches S_HALT, halted=1, mem_req stays 0 for 20 cycles, retired unchanged by the HALT.
- TIMEOUT=15, mem_ready held 0 in FETCH -> fault=1 after 15 wait cycles, mem_req=0 thereafter; rst clears fault. Repeat with mem_ready=1 on wait cycle 15 -> accept, no fault.
- sw (101) with rst asserted on the second MEM wait cycle -> write_mem never accepted, retired unchanged, FETCH on the cycle after reset release.
